// File: rtl/arb_pkg.sv
// arb_pkg: shared encodings and sizes for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int ARB_NUM_REQ = 8;
    localparam int ARB_IDX_W   = 3;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
endpackage

// File: rtl/dec_3to8_en.sv
// dec_3to8_en: enabled 3-to-8 one-hot decoder.
module dec_3to8_en (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);
    assign onehot = en ? (8'b1 << sel) : 8'b0;
endmodule

// File: rtl/rr_arb_8.sv
// rr_arb_8: round-robin arbiter with break-before-make grant hand-off.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arb_8
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic               gnt_en,
    output logic [IDX_W-1:0]   gnt_sel,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic               busy,
    output logic               timeout
);
    if (NUM_REQ != 8 || IDX_W != $clog2(NUM_REQ) || MAX_HOLD < 2 || MAX_HOLD > 255)
        $error("rr_arb_8: unsupported parameter set");

    state_t                 state;
    logic   [IDX_W-1:0]     ptr;
    logic   [IDX_W-1:0]     idx;
    logic   [IDX_W-1:0]     win;
    logic   [2*NUM_REQ-1:0] dbl;
    logic   [NUM_REQ-1:0]   rot;
    logic                   expire;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) idx = i[IDX_W-1:0];
    end
    assign win  = ptr + idx;
    assign busy = (state == ST_GRANT);

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    assign expire = (hold_cnt == 8'(MAX_HOLD - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= busy ? hold_cnt + 8'd1 : 8'd0;
            timeout  <= busy && req[gnt_sel] && expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            gnt_en  <= 1'b0;
            gnt_sel <= '0;
            ptr     <= '0;
        end else if (state == ST_IDLE) begin
            if (|req) begin
                state   <= ST_GRANT;
                gnt_en  <= 1'b1;
                gnt_sel <= win;
                ptr     <= win + IDX_W'(1);
            end
        end else if (!req[gnt_sel] || expire) begin
            state  <= ST_IDLE;
            gnt_en <= 1'b0;
        end
    end

    dec_3to8_en u_dec (
        .en     (gnt_en),
        .sel    (gnt_sel),
        .onehot (gnt_onehot)
    );
endmodule

// File: tb/tb_rr_arb_8.sv
// tb_rr_arb_8: randomized and directed checks of rr_arb_8 against a behavioural model.
module tb_rr_arb_8;
`ifdef RR_ARB_TIMEOUT_EN
    localparam int MH = 4;
    localparam bit TO = 1'b1;
`else
    localparam int MH = 16;
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       gnt_en;
    logic [2:0] gnt_sel;
    logic [7:0] gnt_onehot;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arb_8 #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt_en     (gnt_en),
        .gnt_sel    (gnt_sel),
        .gnt_onehot (gnt_onehot),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Model: owner index or none, next-priority position, cycles held so far.
    bit m_valid = 0;
    bit m_en = 0;
    int m_sel = 0;
    int m_ptr = 0;
    int m_held = 0;
    bit m_to = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (reset) begin
            m_en = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_en) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (!m_en && req[(m_ptr + k) % 8]) begin
                    m_en = 1;
                    m_sel = (m_ptr + k) % 8;
                end
            end
            if (m_en) begin
                m_ptr = (m_sel + 1) % 8;
                m_held = 1;
            end
        end else begin
            m_to = 0;
            if (!req[m_sel]) m_en = 0;
            else if (TO && m_held == MH) begin
                m_en = 0;
                m_to = 1;
            end else m_held++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gnt_en", gnt_en, m_en);
            chk("model_gnt_sel", gnt_sel, m_sel);
            chk("model_onehot", gnt_onehot, m_en ? (1 << m_sel) : 0);
            chk("model_busy", busy, m_en);
            chk("model_timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all requesting
        reset = 1; req = 8'hFF;
        tick();
        tick();
        chk("rst_gnt_en", gnt_en, 0);
        chk("rst_onehot", gnt_onehot, 0);
        chk("rst_busy", busy, 0);
        reset = 0;
        tick();
        chk("first_sel", gnt_sel, 0);
        chk("first_onehot", gnt_onehot, 8'h01);
        // rotation with a single gap between owners
        for (int g = 0; g < 8; g++) begin
            tick();
            tick();
            req = 8'hFF & ~(8'h01 << g);
            tick();
            chk("rot_gap", gnt_onehot, 0);
            req = 8'hFF;
            tick();
            chk("rot_next", gnt_onehot, 1 << ((g + 1) % 8));
        end
        // move ptr to 6 by granting 5, then wrap/skip
        req = 8'h20;
        tick();
        tick();
        chk("grant5", gnt_sel, 5);
        req = 8'h00;
        tick();
        req = 8'h05;
        tick();
        chk("wrap_sel0", gnt_sel, 0);
        req = 8'h04;
        tick();
        tick();
        chk("skip_sel2", gnt_sel, 2);
        chk("skip_en", gnt_en, 1);
        // no preemption
        req = 8'h00;
        tick();
        req = 8'h08;
        tick();
        chk("np_grant3", gnt_onehot, 8'h08);
        req = 8'h28;
`ifndef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("np_hold3", gnt_onehot, 8'h08);
        end
`endif
        req = 8'h20;
        tick();
        chk("np_gap", gnt_en, 0);
        tick();
        chk("np_grant5", gnt_onehot, 8'h20);
        // hold / timeout behaviour with a sole requester
        req = 8'h00;
        tick();
        req = 8'h02;
        tick();
        chk("to_grant1", gnt_onehot, 8'h02);
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("to_held", gnt_en, 1);
            chk("to_nopulse", timeout, 0);
        end
        tick();
        chk("to_release", gnt_en, 0);
        chk("to_pulse", timeout, 1);
        tick();
        chk("to_regrant", gnt_onehot, 8'h02);
        chk("to_pulse_end", timeout, 0);
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("persist_en", gnt_onehot, 8'h02);
            chk("persist_to", timeout, 0);
        end
`endif
        // reset mid-grant
        req = 8'h20;
        tick();
        tick();
        chk("mid_grant5", gnt_onehot, 8'h20);
        reset = 1;
        tick();
        chk("mid_rst_en", gnt_en, 0);
        reset = 0; req = 8'hFF;
        tick();
        chk("mid_after_sel", gnt_onehot, 8'h01);
        // random traffic, checked every cycle by the model compare
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 7) == 0 && gnt_en) req[gnt_sel] = 1'b0;
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
